// File: rtl/addsub_arbiter_if.sv
// Request/response bundle for addsub_arbiter.
// Handshake rule on every channel: a transfer happens on the rising clock
// edge where valid and ready are both 1. The producer may drop valid before
// the transfer; nothing is latched until the transfer happens.
// dbg_state mirrors the arbiter's EMPTY/FULL state so it can be observed.
interface addsub_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req0_sub;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        req1_sub;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_sum;
    logic [2:0]  rsp_flag;
    logic        dbg_state;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_flag,
        output dbg_state
    );

    // Client / consumer side
    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        output req1_valid, req1_a, req1_b, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_flag,
        input  dbg_state
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Two-requester arbiter sharing one 16-bit saturating add/sub unit.
// One operation per cycle, one cycle latency, single shared response register
// tagged with the requester ID. FIXED_PRIO=0 round-robin, 1 = requester 0 wins.
// Optional macro ADDSUB_ARB_STATS_EN adds grant and saturation counters.
module addsub_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    addsub_arbiter_if.slave    bus
`ifdef ADDSUB_ARB_STATS_EN
    ,
    output logic [15:0]        stat_grant0,
    output logic [15:0]        stat_grant1,
    output logic [15:0]        stat_sat
`endif
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] op_a_q, op_b_q;
    logic        op_sub_q, op_id_q;

    logic        slot_free;
    logic        grant_valid;
    logic        grant_id;
    logic        acc0, acc1, accept;

    logic [16:0] b_ext;
    logic [16:0] sum17;
    logic        ovfl;
    logic [15:0] res_sum;

    // The response register may drain and refill in the same cycle.
    assign slot_free = (state_q == ST_EMPTY) | bus.rsp_ready;

    // Pick the winner from the valids; readiness itself is gated by slot_free.
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign bus.req0_ready = ~rst & slot_free & grant_valid & ~grant_id;
    assign bus.req1_ready = ~rst & slot_free & grant_valid & grant_id;

    assign acc0   = bus.req0_valid & bus.req0_ready;
    assign acc1   = bus.req1_valid & bus.req1_ready;
    assign accept = acc0 | acc1;

    // EMPTY/FULL transitions and round-robin pointer update.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            default:  if (bus.rsp_ready && !accept) state_d = ST_EMPTY;
        endcase
        if (accept && (FIXED_PRIO == 0)) last_grant_d = acc1;
    end

    // Operand capture on accept; pointer resets to 1 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            last_grant_q <= 1'b1;
            op_a_q       <= 16'h0000;
            op_b_q       <= 16'h0000;
            op_sub_q     <= 1'b0;
            op_id_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            if (accept) begin
                op_a_q   <= acc1 ? bus.req1_a   : bus.req0_a;
                op_b_q   <= acc1 ? bus.req1_b   : bus.req0_b;
                op_sub_q <= acc1 ? bus.req1_sub : bus.req0_sub;
                op_id_q  <= acc1;
            end
        end
    end

    // Saturating add/sub on the held operands; 17-bit sign-extended datapath
    // so overflow shows as disagreement of the top two bits.
    always_comb begin
        b_ext   = op_sub_q ? (~{op_b_q[15], op_b_q} + 17'd1) : {op_b_q[15], op_b_q};
        sum17   = {op_a_q[15], op_a_q} + b_ext;
        ovfl    = sum17[16] ^ sum17[15];
        res_sum = sum17[15:0];
        if (ovfl) res_sum = sum17[16] ? 16'h8000 : 16'h7FFF;
    end

    assign bus.rsp_valid = ~rst & (state_q == ST_FULL);
    assign bus.rsp_id    = op_id_q;
    assign bus.rsp_sum   = res_sum;
    assign bus.rsp_flag  = {res_sum[15], ovfl, (res_sum == 16'h0000)};
    assign bus.dbg_state = state_q[0];

`ifdef ADDSUB_ARB_STATS_EN
    logic [15:0] cnt_g0_q, cnt_g1_q, cnt_sat_q;

    // Saturating event counters: accepts per requester, saturated deliveries.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_g0_q  <= 16'h0000;
            cnt_g1_q  <= 16'h0000;
            cnt_sat_q <= 16'h0000;
        end else begin
            if (acc0 && cnt_g0_q != 16'hFFFF) cnt_g0_q <= cnt_g0_q + 16'd1;
            if (acc1 && cnt_g1_q != 16'hFFFF) cnt_g1_q <= cnt_g1_q + 16'd1;
            if (bus.rsp_valid && bus.rsp_ready && ovfl && cnt_sat_q != 16'hFFFF)
                cnt_sat_q <= cnt_sat_q + 16'd1;
        end
    end

    assign stat_grant0 = cnt_g0_q;
    assign stat_grant1 = cnt_g1_q;
    assign stat_sat    = cnt_sat_q;
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter: directed scenario tasks plus a
// negedge monitor that scores every delivered response against a queue of
// results predicted from the accepted requests.
module tb_addsub_arbiter;
  localparam int FIXED_PRIO = 0;
  localparam int W = 20; // {id, sum[15:0], flag[2:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addsub_arbiter_if bus();

`ifdef ADDSUB_ARB_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_sat;
`endif

  addsub_arbiter #(.FIXED_PRIO(FIXED_PRIO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ADDSUB_ARB_STATS_EN
    ,
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
    .stat_sat    (stat_sat)
`endif
  );

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  int exp_g0 = 0;
  int exp_g1 = 0;
  int exp_sat = 0;
  logic [W-1:0] mon_e, mon_got;

  // Reference model: integer arithmetic, then clamp.
  function automatic logic [W-1:0] model(input logic id, input logic [15:0] a,
                                         input logic [15:0] b, input logic sub);
    int r;
    logic [15:0] s;
    logic ov;
    r = sub ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
    ov = 1'b0;
    if (r > 32767) begin
      s = 16'h7FFF; ov = 1'b1;
    end else if (r < -32768) begin
      s = 16'h8000; ov = 1'b1;
    end else begin
      s = r[15:0];
    end
    return {id, s, s[15], ov, (s == 16'h0000)};
  endfunction

  function automatic logic [15:0] pick_operand();
    logic [15:0] edges [6];
    edges = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001, 16'h7FF0};
    if ($urandom_range(0, 2) == 0) return edges[$urandom_range(0, 5)];
    return 16'($urandom_range(0, 65535));
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_g0 = 0; exp_g1 = 0; exp_sat = 0;
    end else begin
      tests++;
      if (bus.rsp_valid !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL rsp_valid_timing: got %b expected %b", bus.rsp_valid, (exp_q.size() != 0));
      end
      tests++;
      if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin
        fails++;
        $display("FAIL one_ready: got ready0=%b ready1=%b expected at most one", bus.req0_ready, bus.req1_ready);
      end
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1 && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        mon_got = {bus.rsp_id, bus.rsp_sum, bus.rsp_flag};
        tests++;
        if (mon_got !== mon_e) begin
          fails++;
          $display("FAIL scoreboard: got id=%b sum=%h flag=%b expected id=%b sum=%h flag=%b",
                   mon_got[19], mon_got[18:3], mon_got[2:0], mon_e[19], mon_e[18:3], mon_e[2:0]);
        end
        if (mon_e[1]) exp_sat++;
      end
      if (bus.req0_valid && bus.req0_ready) begin
        exp_q.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_sub));
        exp_g0++;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        exp_q.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_sub));
        exp_g1++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic n, input logic [15:0] a, input logic [15:0] b, input logic s);
    if (n == 1'b0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = s;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = s;
    end
  endtask

  task automatic idle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  // Lets all outstanding results drain; returns just after a rising edge.
  task automatic drain();
    int k;
    idle();
    bus.rsp_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_op(1'b0, 16'h1111, 16'h2222, 1'b0);
    drive_op(1'b1, 16'h3333, 16'h4444, 1'b1);
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); end
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready: got %b%b expected 00", bus.req0_ready, bus.req1_ready);
    end
    tests++;
    if (bus.rsp_id !== 1'b0) begin fails++; $display("FAIL reset_rsp_id: got %b expected 0", bus.rsp_id); end
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    tests++;
    if (bus.rsp_sum !== 16'h0000 || bus.rsp_flag !== 3'b001) begin
      fails++; $display("FAIL reset_result: got sum=%h flag=%b expected sum=0000 flag=001", bus.rsp_sum, bus.rsp_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    logic exp_id;
    logic g0, g1;
    bus.rsp_ready = 1'b1;
    drive_op(1'b0, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    drive_op(1'b1, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_id = (FIXED_PRIO != 0) ? 1'b0 : 1'(i % 2);
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      tests++;
      if ({g0, g1} !== {~exp_id, exp_id}) begin
        fails++; $display("FAIL contention_grant%0d: got ready0=%b ready1=%b expected grant %b", i, g0, g1, exp_id);
      end
      tests++;
      if (bus.rsp_valid !== (i != 0)) begin
        fails++; $display("FAIL contention_valid%0d: got %b expected %b", i, bus.rsp_valid, (i != 0));
      end
      @(posedge clk); #1;
      if (g0) drive_op(1'b0, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
      if (g1) drive_op(1'b1, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
    end
    idle();
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL contention_last_valid: got %b expected 1", bus.rsp_valid); end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_single_add();
    bus.rsp_ready = 1'b1;
    drive_op(1'b0, 16'h1234, 16'h0001, 1'b0);
    @(negedge clk);
    tests++;
    if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL single_add_ready: got %b expected 1", bus.req0_ready); end
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    tests++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_flag} !== {1'b1, 1'b0, 16'h1235, 3'b000}) begin
      fails++; $display("FAIL single_add: got v=%b id=%b sum=%h flag=%b expected v=1 id=0 sum=1235 flag=000",
                        bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_flag);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_saturation();
    logic        t_id   [3];
    logic [15:0] t_a    [3];
    logic [15:0] t_b    [3];
    logic        t_sub  [3];
    logic [15:0] t_sum  [3];
    logic [2:0]  t_flag [3];
    t_id = '{1'b1, 1'b1, 1'b0};
    t_a = '{16'h7FF0, 16'h0005, 16'h8000};
    t_b = '{16'h0020, 16'h0005, 16'h0001};
    t_sub = '{1'b0, 1'b1, 1'b1};
    t_sum = '{16'h7FFF, 16'h0000, 16'h8000};
    t_flag = '{3'b010, 3'b001, 3'b110};
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op(t_id[i], t_a[i], t_b[i], t_sub[i]);
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      tests++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_flag} !== {1'b1, t_id[i], t_sum[i], t_flag[i]}) begin
        fails++; $display("FAIL saturation%0d: got v=%b id=%b sum=%h flag=%b expected v=1 id=%b sum=%h flag=%b",
                          i, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_flag, t_id[i], t_sum[i], t_flag[i]);
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [15:0] a, b;
    logic s;
    logic [W-1:0] exp_hold;
    logic exp_id;
    a = pick_operand(); b = pick_operand(); s = 1'($urandom_range(0, 1));
    exp_hold = model(1'b0, a, b, s);
    bus.rsp_ready = 1'b0;
    drive_op(1'b0, a, b, s);
    @(negedge clk);
    tests++;
    if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL bp_first_ready: got %b expected 1", bus.req0_ready); end
    @(posedge clk); #1;
    drive_op(1'b0, pick_operand(), pick_operand(), 1'b0);
    drive_op(1'b1, pick_operand(), pick_operand(), 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        fails++; $display("FAIL bp_hold_ready%0d: got %b%b expected 00", i, bus.req0_ready, bus.req1_ready);
      end
      tests++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_flag} !== {1'b1, exp_hold}) begin
        fails++; $display("FAIL bp_hold_rsp%0d: got v=%b id=%b sum=%h flag=%b expected v=1 id=%b sum=%h flag=%b",
                          i, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_flag,
                          exp_hold[19], exp_hold[18:3], exp_hold[2:0]);
      end
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    // Last accept before the hold was requester 0.
    exp_id = (FIXED_PRIO != 0) ? 1'b0 : 1'b1;
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== {~exp_id, exp_id}) begin
      fails++; $display("FAIL bp_refill: got ready0=%b ready1=%b expected grant %b", bus.req0_ready, bus.req1_ready, exp_id);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.req0_valid = 1'($urandom_range(0, 1));
      bus.req1_valid = 1'($urandom_range(0, 1));
      bus.req0_a = pick_operand(); bus.req0_b = pick_operand(); bus.req0_sub = 1'($urandom_range(0, 1));
      bus.req1_a = pick_operand(); bus.req1_b = pick_operand(); bus.req1_sub = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drain();
`ifdef ADDSUB_ARB_STATS_EN
    @(negedge clk);
    tests++;
    if (stat_grant0 !== 16'(exp_g0) || stat_grant1 !== 16'(exp_g1) || stat_sat !== 16'(exp_sat)) begin
      fails++; $display("FAIL stats: got g0=%0d g1=%0d sat=%0d expected g0=%0d g1=%0d sat=%0d",
                        stat_grant0, stat_grant1, stat_sat, exp_g0, exp_g1, exp_sat);
    end
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset_midop();
    bus.rsp_ready = 1'b0;
    drive_op(1'b0, 16'h0100, 16'h0200, 1'b0);
    @(posedge clk); #1;
    idle();
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b1) begin fails++; $display("FAIL midop_pending: got %b expected 1", bus.rsp_valid); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    drive_op(1'b0, 16'h0003, 16'h0004, 1'b0);
    drive_op(1'b1, 16'h0005, 16'h0006, 1'b1);
    @(negedge clk);
    tests++;
    if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL midop_discard: got %b expected 0", bus.rsp_valid); end
    tests++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      fails++; $display("FAIL midop_first_grant: got %b%b expected 10", bus.req0_ready, bus.req1_ready);
    end
`ifdef ADDSUB_ARB_STATS_EN
    tests++;
    if ({stat_grant0, stat_grant1, stat_sat} !== 48'h0) begin
      fails++; $display("FAIL midop_stats: got %0d %0d %0d expected 0 0 0", stat_grant0, stat_grant1, stat_sat);
    end
`endif
    @(posedge clk); #1;
    drain();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    idle();
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_contention();
    test_single_add();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
Two-requester arbiter and sequencer that time-shares a single addsub_16bit instance (16-bit saturating add/sub with {sign, ovfl, zero} flags) between two clients, e.g. the execute-stage ALU path and an address/auxiliary path.
- Each client uses a valid/ready request handshake.
- Results return on one shared response channel, tagged with the requester ID and subject to backpressure.
- Throughput is one operation per cycle; latency is one cycle.

Parameters:
FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 has strict priority.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle when valid&ready
req0_a  input  16  requester 0 operand A
req0_b  input  16  requester 0 operand B
req0_sub  input  1  requester 0: 1 = A-B, 0 = A+B
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 accept
req1_a  input  16  requester 1 operand A
req1_b  input  16  requester 1 operand B
req1_sub  input  1  requester 1 subtract select
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer takes result when valid&ready
rsp_id  output  1  requester that issued the result
rsp_sum  output  16  saturated sum/difference
rsp_flag  output  3  {sign, ovfl, zero} from addsub_16bit

Behaviour:
- Reset: synchronous, active-high on clk; all state clears.
  - rsp_valid=0, rsp_id=0, req0_ready=req1_ready=0 while rst=1.
  - Operand registers are cleared to 0, so rsp_sum=0 and rsp_flag=3'b001 after reset.
  - Round-robin pointer last_grant=1, so requester 0 wins first.
- Slot free: slot_free = ~rsp_valid | rsp_ready. The response register may drain and refill in the same cycle.
- Grant, combinational, only when slot_free=1:
  - Only one valid: grant that requester.
  - Both valid, FIXED_PRIO=0: grant ~last_grant.
  - Both valid, FIXED_PRIO=1: grant requester 0 always.
  - reqN_ready = slot_free & grant==N. At most one ready is high per cycle.
  - ready does not depend on the other requester's ready. It may depend on both valids.
- Accept cycle N (valid&ready):
  - Capture a, b, sub and the requester ID into the operand registers.
  - Set rsp_valid=1 at edge N.
  - Update last_grant to the ID, in round-robin mode only.
- Cycle N+1: addsub_16bit evaluates from the operand registers. rsp_sum, rsp_flag and rsp_id present the result. Latency is exactly 1 cycle.
- Hold: while rsp_valid=1 and rsp_ready=0:
  - Operand registers and rsp_* stay stable.
  - No grant is issued; both readys are 0.
- Drain with no new accept: rsp_valid falls at the next edge.
- Saturation and flags come unmodified from addsub_16bit:
  - Positive overflow gives 0x7FFF; negative overflow gives 0x8000.
  - zero and sign are computed on the saturated value.
- State machine, two states:
  - EMPTY (rsp_valid=0) -> FULL on accept.
  - FULL -> FULL on drain with simultaneous accept, or on hold.
  - FULL -> EMPTY on drain with no accept.
- Requester valid may drop without ready. No request is latched until it is accepted.
- Reset mid-operation: any pending result is discarded with no response; the pointer returns to its reset value.
- A requester held valid for consecutive cycles with both requesters valid alternates grants 0,1,0,1 in round-robin mode.

Optional Feature:
Macro ADDSUB_ARB_STATS_EN.
- When defined, three 16-bit output ports are added:
  - stat_grant0: count of accepts from requester 0.
  - stat_grant1: count of accepts from requester 1.
  - stat_sat: count of results delivered with rsp_flag[1]=1, counted on the response handshake.
- All counters saturate at 0xFFFF and clear on rst.
- When undefined, the ports and logic are absent and the behaviour above is unchanged.

Test Plan:
- Single add: req0 0x1234+0x0001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x1235, rsp_flag=3'b000.
- Positive saturation: req1 0x7FF0+0x0020 -> rsp_sum=0x7FFF, rsp_id=1, rsp_flag=3'b010. Then 0x0005-0x0005 -> rsp_sum=0x0000, rsp_flag=3'b001.
- Negative saturation: req0 0x8000-0x0001 -> rsp_sum=0x8000, rsp_flag=3'b110.
- Contention, FIXED_PRIO=0: both valid for 4 cycles, rsp_ready=1 -> grants 0,1,0,1, rsp_valid high on 4 consecutive cycles. With FIXED_PRIO=1 -> grants 0,0,0,0.
- Backpressure: rsp_ready=0 for 3 cycles after accept -> both readys 0, rsp_* stable. Then rsp_ready=1 -> drain plus new accept in the same cycle.
- Reset mid-op: assert rst while rsp_valid=1 -> next cycle rsp_valid=0, first grant after reset goes to req0. With ADDSUB_ARB_STATS_EN, counters read 0.
